// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared TLC constants, register map and writer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

  localparam int TLC_ADDR_RED    = 0;
  localparam int TLC_ADDR_YELLOW = 1;
  localparam int TLC_ADDR_GREEN  = 2;
  localparam int TLC_MIN_TIME    = 1;
  localparam int TLC_TIMEOUT     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } tlc_state_e;

  typedef enum logic [1:0] {
    IDX_RED    = 2'd0,
    IDX_YELLOW = 2'd1,
    IDX_GREEN  = 2'd2
  } tlc_idx_e;

endpackage
`default_nettype wire

// File: rtl/tlc_wr_timer.sv
`default_nettype none
// ============================================================================
// Module      : tlc_wr_timer
// Description : Per-phase timeout counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_wr_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count is zero during the first cycle of a phase, so this flags the
  // TIMEOUT-th cycle and the phase ends on the following edge.
  assign expired = (r_count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/tlc_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module      : tlc_cfg_writer
// Description : Programs red/yellow/green durations into the TLC over a
//               valid/ready register-write handshake, with per-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_cfg_writer #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_RED    = tlc_pkg::TLC_ADDR_RED,
  parameter int ADDR_YELLOW = tlc_pkg::TLC_ADDR_YELLOW,
  parameter int ADDR_GREEN  = tlc_pkg::TLC_ADDR_GREEN,
  parameter int MIN_TIME    = tlc_pkg::TLC_MIN_TIME,
  parameter int TIMEOUT     = tlc_pkg::TLC_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] t_red,
  input  logic [DATA_WIDTH-1:0] t_yellow,
  input  logic [DATA_WIDTH-1:0] t_green,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import tlc_pkg::*;

  tlc_state_e            r_state, w_state_nxt;
  tlc_idx_e              r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_snap_red, r_snap_yellow, r_snap_green;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_load_snap;
  logic                  w_timer_clr;
  logic                  w_timer_en;
  logic                  w_expired;

  function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH-1:0] v);
    return (v == '0) ? DATA_WIDTH'(MIN_TIME) : v;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_err_nxt   = r_err;
    w_load_snap = 1'b0;
    w_timer_clr = 1'b0;
    valid       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_WRITE;
          w_idx_nxt   = IDX_RED;
          w_addr_nxt  = ADDR_WIDTH'(ADDR_RED);
          w_data_nxt  = clamp(t_red);
          w_err_nxt   = 1'b0;
          w_load_snap = 1'b1;
          w_timer_clr = 1'b1;
        end
      end

      ST_WRITE: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready) begin
          w_state_nxt = ST_GAP;
          w_timer_clr = 1'b1;
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end
      end

      // Wait for ready to fall so a stale acknowledge cannot complete the next write.
      ST_GAP: begin
        busy = 1'b1;
        if (!ready) begin
          unique case (r_idx)
            IDX_RED: begin
              w_state_nxt = ST_WRITE;
              w_idx_nxt   = IDX_YELLOW;
              w_addr_nxt  = ADDR_WIDTH'(ADDR_YELLOW);
              w_data_nxt  = r_snap_yellow;
              w_timer_clr = 1'b1;
            end
            IDX_YELLOW: begin
              w_state_nxt = ST_WRITE;
              w_idx_nxt   = IDX_GREEN;
              w_addr_nxt  = ADDR_WIDTH'(ADDR_GREEN);
              w_data_nxt  = r_snap_green;
              w_timer_clr = 1'b1;
            end
            default: begin
              w_state_nxt = ST_FINISH;
            end
          endcase
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end
      end

      ST_FINISH: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= IDX_RED;
      r_snap_red    <= '0;
      r_snap_yellow <= '0;
      r_snap_green  <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
      if (w_load_snap) begin
        r_snap_red    <= clamp(t_red);
        r_snap_yellow <= clamp(t_yellow);
        r_snap_green  <= clamp(t_green);
      end
    end
  end

  assign w_timer_en = (r_state == ST_WRITE) || (r_state == ST_GAP);

  tlc_wr_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clr),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  assign addr = r_addr;
  assign data = r_data;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tlc_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlc_cfg_writer
// Description : Directed self-checking bench for tlc_cfg_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_cfg_writer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] t_red, t_yellow, t_green;
  logic [2:0] addr;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic       err;

  logic [1:0] mode;
  logic       resp;
  logic       force_ready;
  int         hi_cnt = 0;
  int         lo_cnt = 0;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         hs_count = 0;
  int         done_count = 0;
  logic [2:0] log_addr [0:31];
  logic [7:0] log_data [0:31];

  tlc_cfg_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .t_red    (t_red),
    .t_yellow (t_yellow),
    .t_green  (t_green),
    .addr     (addr),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ready = resp | force_ready;

  // Registered TLC responder: 0 = ideal, 1 = never ready, 2 = slow.
  initial resp = 1'b0;
  always @(posedge clk) begin
    case (mode)
      2'd0: resp <= valid;
      2'd1: resp <= 1'b0;
      default: begin
        if (valid) begin
          hi_cnt <= hi_cnt + 1;
          lo_cnt <= 0;
        end else begin
          lo_cnt <= lo_cnt + 1;
          hi_cnt <= 0;
        end
        if (!resp && valid && hi_cnt == 2) resp <= 1'b1;
        else if (resp && !valid && lo_cnt == 2) resp <= 1'b0;
      end
    endcase
  end

  always @(posedge clk) begin
    if (rst && valid && ready && hs_count < 32) begin
      log_addr[hs_count] = addr;
      log_data[hs_count] = data;
      hs_count++;
    end
    if (rst && done) done_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int i, input logic [2:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, 32'(log_addr[i]), 32'(a));
    chk({tag, "_data"}, 32'(log_data[i]), 32'(d));
  endtask

  task automatic do_start(input logic [7:0] r, input logic [7:0] y, input logic [7:0] g);
    @(negedge clk);
    t_red = r; t_yellow = y; t_green = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_idle(input string tag, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, dbase, n_valid;
    rst = 1'b0; start = 1'b0; mode = 2'd0; force_ready = 1'b0;
    t_red = '0; t_yellow = '0; t_green = '0;

    #2;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_addr",  32'(addr),  32'd0);
    chk("rst_data",  32'(data),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ready asserted while idle is ignored
    @(negedge clk);
    force_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy_valid", 32'(valid), 32'd0);
    chk("idle_rdy_busy",  32'(busy),  32'd0);
    chk("idle_rdy_hs",    32'(hs_count), 32'd0);
    force_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal: exact cycle timing with the ideal responder
    base = hs_count; dbase = done_count;
    do_start(8'd5, 8'd2, 8'd7);
    chk("nom_valid", 32'(valid), 32'd1);
    chk("nom_addr",  32'(addr),  32'd0);
    chk("nom_data",  32'(data),  32'd5);
    chk("nom_busy",  32'(busy),  32'd1);
    repeat (11) @(negedge clk);
    chk("nom_done_e12", 32'(done), 32'd0);
    @(negedge clk);
    chk("nom_done_e13", 32'(done), 32'd1);
    @(negedge clk);
    chk("nom_done_e14", 32'(done), 32'd0);
    chk("nom_busy_e14", 32'(busy), 32'd0);
    chk("nom_hs",   32'(hs_count - base), 32'd3);
    chk("nom_dcnt", 32'(done_count - dbase), 32'd1);
    chk_log("nom_w0", base,     3'd0, 8'd5);
    chk_log("nom_w1", base + 1, 3'd1, 8'd2);
    chk_log("nom_w2", base + 2, 3'd2, 8'd7);

    // Zero clamp on yellow
    base = hs_count;
    do_start(8'd9, 8'd0, 8'd200);
    run_idle("clamp_idle", 100);
    chk("clamp_hs", 32'(hs_count - base), 32'd3);
    chk_log("clamp_w0", base,     3'd0, 8'd9);
    chk_log("clamp_w1", base + 1, 3'd1, 8'd1);
    chk_log("clamp_w2", base + 2, 3'd2, 8'd200);

    // Timeout with ready tied low
    mode = 2'd1;
    base = hs_count; dbase = done_count;
    do_start(8'd3, 8'd3, 8'd3);
    n_valid = 0;
    for (int i = 0; i < 24; i++) begin
      if (valid) n_valid++;
      @(negedge clk);
    end
    chk("to_valid_cycles", 32'(n_valid), 32'd16);
    chk("to_err",  32'(err),  32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_done", 32'(done_count - dbase), 32'd0);
    chk("to_hs",   32'(hs_count - base), 32'd0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 32'(err), 32'd1);
    mode = 2'd0;
    dbase = done_count;
    do_start(8'd4, 8'd4, 8'd4);
    chk("to_err_clr", 32'(err), 32'd0);
    run_idle("to_rerun_idle", 100);
    chk("to_rerun_done", 32'(done_count - dbase), 32'd1);

    // Start while busy is ignored
    base = hs_count; dbase = done_count;
    do_start(8'd8, 8'd9, 8'd10);
    repeat (4) @(negedge clk);
    chk("busy_yaddr",  32'(addr),  32'd1);
    chk("busy_yvalid", 32'(valid), 32'd1);
    t_red = 8'd99; t_yellow = 8'd98; t_green = 8'd97;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_idle("busy_idle", 100);
    repeat (2) @(negedge clk);
    chk("busy_norestart", 32'(busy), 32'd0);
    chk("busy_hs",   32'(hs_count - base), 32'd3);
    chk("busy_done", 32'(done_count - dbase), 32'd1);
    chk_log("busy_w0", base,     3'd0, 8'd8);
    chk_log("busy_w1", base + 1, 3'd1, 8'd9);
    chk_log("busy_w2", base + 2, 3'd2, 8'd10);

    // Asynchronous reset in GAP after the red write
    base = hs_count; dbase = done_count;
    do_start(8'd4, 8'd5, 8'd6);
    repeat (2) @(negedge clk);
    chk("mid_gap_valid", 32'(valid), 32'd0);
    chk("mid_gap_busy",  32'(busy),  32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_done",  32'(done),  32'd0);
    chk("mid_rst_addr",  32'(addr),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_stay_idle", 32'(busy), 32'd0);
    chk("mid_hs",   32'(hs_count - base), 32'd1);
    chk("mid_done", 32'(done_count - dbase), 32'd0);

    // Slow responder
    mode = 2'd2;
    base = hs_count; dbase = done_count;
    do_start(8'd3, 8'd4, 8'd6);
    run_idle("slow_idle", 200);
    chk("slow_hs",   32'(hs_count - base), 32'd3);
    chk("slow_done", 32'(done_count - dbase), 32'd1);
    chk("slow_err",  32'(err), 32'd0);
    chk_log("slow_w0", base,     3'd0, 8'd3);
    chk_log("slow_w1", base + 1, 3'd1, 8'd4);
    chk_log("slow_w2", base + 2, 3'd2, 8'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
